// File: rtl/riscv_iitb_pkg.sv
// Shared IITB-RISC definitions used by the LM/SM sequencer.
package riscv_iitb_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned MASK_W = 8;

   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

   typedef enum logic {
      IDLE,
      ISSUE
   } seq_state_e;

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit encoder: index, one-hot clear mask and single-bit flag.
module lsb_priority_enc #(
   parameter int unsigned MASK_W = 8,
   parameter int unsigned REG_W  = 3
) (
   input  logic [MASK_W-1:0] i_mask,
   output logic [REG_W-1:0]  o_idx,
   output logic [MASK_W-1:0] o_clr,
   output logic              o_single
);

   // Isolates the lowest set bit (two's complement trick).
   assign o_clr    = i_mask & (~i_mask + MASK_W'(1));
   assign o_single = (i_mask != '0) && ((i_mask & (i_mask - MASK_W'(1))) == '0);

   always_comb begin
      o_idx = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_idx = REG_W'(i);
         end
      end
   end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands an LM/SM instruction into one load/store micro-op per set mask bit.
module lm_sm_sequencer
   import riscv_iitb_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned MASK_W = 8,
   parameter int unsigned REG_W  = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [15:0]       in_instr,
   input  logic [ADDR_W-1:0] in_base,
   output logic              in_ready,
   input  logic              stall_in,
   output logic              stall_fetch,
   output logic              uop_valid,
   output logic              uop_is_load,
   output logic [REG_W-1:0]  uop_reg,
   output logic [ADDR_W-1:0] uop_addr,
   output logic              uop_last
);

   seq_state_e        r_state;
   logic [MASK_W-1:0] r_mask;
   logic [ADDR_W-1:0] r_addr;
   logic              r_is_load;
   logic              r_uop_valid;

   logic [3:0]        w_opcode;
   logic [MASK_W-1:0] w_in_mask;
   logic              w_is_lmsm;
   logic              w_accept;
   logic              w_consume;
   logic [MASK_W-1:0] w_clr;
   logic [REG_W-1:0]  w_idx;
   logic              w_single;
   logic              w_unused_instr;

   assign w_opcode       = in_instr[15:12];
   assign w_in_mask      = in_instr[MASK_W-1:0];
   assign w_unused_instr = ^in_instr[11:MASK_W];
   assign w_is_lmsm      = (w_opcode == OP_LM) || (w_opcode == OP_SM);
   assign in_ready       = (r_state == IDLE);
   assign w_accept       = resetn & in_valid & in_ready & w_is_lmsm & ~flush;
   assign w_consume      = r_uop_valid & ~stall_in;

   // Encoder runs on the remaining mask, so the current micro-op is a decode of state.
   lsb_priority_enc #(
      .MASK_W (MASK_W),
      .REG_W  (REG_W)
   ) u_enc (
      .i_mask   (r_mask),
      .o_idx    (w_idx),
      .o_clr    (w_clr),
      .o_single (w_single)
   );

   assign uop_valid   = r_uop_valid;
   assign uop_is_load = r_is_load;
   assign uop_reg     = w_idx;
   assign uop_addr    = r_addr;
   assign uop_last    = w_single;

   // Combinational so that fetch freezes in the accepting cycle itself.
   assign stall_fetch = (w_accept & (w_in_mask != '0)) |
                        ((r_state == ISSUE) & ~(w_single & ~stall_in));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_mask      <= '0;
         r_addr      <= '0;
         r_is_load   <= 1'b0;
         r_uop_valid <= 1'b0;
      end else if (flush) begin
         r_state     <= IDLE;
         r_mask      <= '0;
         r_uop_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && (w_in_mask != '0)) begin
                  r_state     <= ISSUE;
                  r_mask      <= w_in_mask;
                  r_addr      <= in_base;
                  r_is_load   <= (w_opcode == OP_LM);
                  r_uop_valid <= 1'b1;
               end
            end
            ISSUE: begin
               if (w_consume) begin
                  r_mask <= r_mask & ~w_clr;
                  r_addr <= r_addr + ADDR_W'(1);
                  if (w_single) begin
                     r_state     <= IDLE;
                     r_uop_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_mask      <= '0;
               r_uop_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed table-driven bench for lm_sm_sequencer plus a stalled SM sequence.
module tb_lm_sm_sequencer;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_instr;
   logic [15:0] in_base;
   logic        in_ready;
   logic        stall_in;
   logic        stall_fetch;
   logic        uop_valid;
   logic        uop_is_load;
   logic [2:0]  uop_reg;
   logic [15:0] uop_addr;
   logic        uop_last;

   int checks   = 0;
   int failures = 0;

   lm_sm_sequencer #(
      .ADDR_W (16),
      .MASK_W (8),
      .REG_W  (3)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_instr    (in_instr),
      .in_base     (in_base),
      .in_ready    (in_ready),
      .stall_in    (stall_in),
      .stall_fetch (stall_fetch),
      .uop_valid   (uop_valid),
      .uop_is_load (uop_is_load),
      .uop_reg     (uop_reg),
      .uop_addr    (uop_addr),
      .uop_last    (uop_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each row: inputs for the cycle, then outputs expected before its rising edge.
   typedef struct packed {
      logic        rn;
      logic        fl;
      logic        iv;
      logic [15:0] ins;
      logic [15:0] base;
      logic        st;
      logic        cc;
      logic        cu;
      logic        rdy;
      logic        sf;
      logic        vld;
      logic        ld;
      logic [2:0]  rg;
      logic [15:0] ad;
      logic        lst;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rn, logic fl, logic iv, logic [15:0] ins,
                               logic [15:0] base, logic st, logic cc, logic cu,
                               logic rdy, logic sf, logic vld, logic ld,
                               logic [2:0] rg, logic [15:0] ad, logic lst);
      vec_t v;
      v = '{rn, fl, iv, ins, base, st, cc, cu, rdy, sf, vld, ld, rg, ad, lst};
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got %h want %h", nm, idx, act, exp);
      end
   endtask

   initial begin
      resetn   = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      in_base  = '0;
      stall_in = 1'b0;

      // reset, then LM 0xA5 @0x0100
      vq.push_back(mk(0,0,0,16'h0000,16'h0000,0, 0,0, 0,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 1,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,1,16'h60A5,16'h0100,0, 1,0, 1,1,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,0,16'h0100,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,2,16'h0101,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,5,16'h0102,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,0,1, 1,7,16'h0103,1));
      // SM 0x80 @0x2000, three stalled cycles
      vq.push_back(mk(1,0,1,16'h7080,16'h2000,0, 1,0, 1,1,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,1, 1,1, 0,1,1, 0,7,16'h2000,1));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,1, 1,1, 0,1,1, 0,7,16'h2000,1));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,1, 1,1, 0,1,1, 0,7,16'h2000,1));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,0,1, 0,7,16'h2000,1));
      // zero-mask LM, then ADD is ignored
      vq.push_back(mk(1,0,1,16'h6000,16'h1234,0, 1,0, 1,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,0, 1,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,1,16'h00FF,16'h0000,0, 1,0, 1,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,0, 1,0,0, 0,0,16'h0000,0));
      // LM 0xFF @0xFFFE wraps
      vq.push_back(mk(1,0,1,16'h60FF,16'hFFFE,0, 1,0, 1,1,0, 0,0,16'h0000,0));
      for (int i = 0; i < 8; i++) begin
         vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,(i != 7),1, 1,3'(i),
                         16'hFFFE + 16'(i), (i == 7)));
      end
      // LM 0xFF @0x0300 flushed while R3 is valid, then SM 0x06 @0x0400
      vq.push_back(mk(1,0,1,16'h60FF,16'h0300,0, 1,0, 1,1,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,0,16'h0300,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,1,16'h0301,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,2,16'h0302,0));
      vq.push_back(mk(1,1,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,3,16'h0303,0));
      vq.push_back(mk(1,0,1,16'h7006,16'h0400,0, 1,0, 1,1,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 0,1,16'h0400,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,0,1, 0,2,16'h0401,1));
      // LM 0x0F @0x0500, reset after R1
      vq.push_back(mk(1,0,1,16'h600F,16'h0500,0, 1,0, 1,1,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,0,16'h0500,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,1,16'h0501,0));
      vq.push_back(mk(0,0,0,16'h0000,16'h0000,0, 1,1, 0,1,1, 1,2,16'h0502,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,1, 1,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,0, 1,0,0, 0,0,16'h0000,0));
      vq.push_back(mk(1,0,0,16'h0000,16'h0000,0, 1,0, 1,0,0, 0,0,16'h0000,0));

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         resetn   = vq[i].rn;
         flush    = vq[i].fl;
         in_valid = vq[i].iv;
         in_instr = vq[i].ins;
         in_base  = vq[i].base;
         stall_in = vq[i].st;
         #1;
         if (vq[i].cc) begin
            chk("in_ready", i, 16'(in_ready), 16'(vq[i].rdy));
            chk("stall_fetch", i, 16'(stall_fetch), 16'(vq[i].sf));
            chk("uop_valid", i, 16'(uop_valid), 16'(vq[i].vld));
         end
         if (vq[i].cu) begin
            chk("uop_is_load", i, 16'(uop_is_load), 16'(vq[i].ld));
            chk("uop_reg", i, 16'(uop_reg), 16'(vq[i].rg));
            chk("uop_addr", i, uop_addr, vq[i].ad);
            chk("uop_last", i, 16'(uop_last), 16'(vq[i].lst));
         end
      end

      // Instruction offered together with a flush in IDLE is dropped.
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 16'h60FF;
      in_base  = 16'h0700;
      #1;
      chk("flush_drop_sf", 0, 16'(stall_fetch), 16'd0);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_drop_vld", 0, 16'(uop_valid), 16'd0);
      chk("flush_drop_rdy", 0, 16'(in_ready), 16'd1);

      // SM 0x0C @0x0010 with an irregular stall pattern.
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 16'h700C;
      in_base  = 16'h0010;
      #1;
      chk("seqb_accept_sf", 0, 16'(stall_fetch), 16'd1);
      begin
         int  n;
         bit  done;
         n    = 0;
         done = 1'b0;
         for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            stall_in = (k == 0 || k == 1 || k == 3);
            #1;
            chk("seqb_vld", k, 16'(uop_valid), 16'd1);
            if (!uop_valid) begin
               done = 1'b1;
            end else begin
               chk("seqb_load", k, 16'(uop_is_load), 16'd0);
               chk("seqb_reg", k, 16'(uop_reg), (n == 0) ? 16'd2 : 16'd3);
               chk("seqb_addr", k, uop_addr, (n == 0) ? 16'h0010 : 16'h0011);
               chk("seqb_last", k, 16'(uop_last), (n == 0) ? 16'd0 : 16'd1);
               chk("seqb_sf", k, 16'(stall_fetch), 16'(!((n == 1) && !stall_in)));
               if (!stall_in) n++;
               if (n == 2) done = 1'b1;
            end
         end
         chk("seqb_count", 0, 16'(n), 16'd2);
      end
      @(negedge clk);
      stall_in = 1'b0;
      #1;
      chk("seqb_done_rdy", 0, 16'(in_ready), 16'd1);
      chk("seqb_done_vld", 0, 16'(uop_valid), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
